ones_pattern_gen: RTL and testbench

Sequential generator that enumerates every N-bit word containing exactly `weight` ones, in ascending numeric order, over a valid/ready stream. It is the inverse companion to the combinational ones counter: the counter maps a word to its weight, and this block maps a weight back to all words of that weight. Its main use is as an exhaustive stimulus source for ones-counting and parity datapaths.

---
 rtl/ones_pkg.sv | 11 +
 rtl/ones_next_comb.sv | 24 ++
 rtl/ones_pattern_gen.sv | 71 +++++++
 tb/tb_ones_pattern_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ones_pkg.sv
// ones_pkg: shared state type, default width and first/last word helpers for ones_pattern_gen
package ones_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int ONES_N = 9;
  function automatic logic [31:0] first_word(input int k);
    return (32'd1 << k) - 32'd1;
  endfunction
  function automatic logic [31:0] last_word(input int k, input int n = ONES_N);
    return first_word(k) << (n - k);
  endfunction
endpackage

// File: rtl/ones_next_comb.sv
// ones_next_comb: next larger word with the same number of ones as x
module ones_next_comb
  import ones_pkg::*;
#(
  parameter int N = ONES_N
) (
  input  logic [N-1:0] x,
  output logic [N-1:0] next
);
  logic [N:0] xe, c, r;
  logic [31:0] tz;
  assign xe = {1'b0, x};
  // priority encoder: position of the lowest set bit
  always_comb begin
    tz = N;
    for (int i = N - 1; i >= 0; i--) tz = x[i] ? i : tz;
  end
  // lowest set bit, then ripple it upward
  always_comb begin
    c = xe & (~xe + 1'b1);
    r = xe + c;
  end
  assign next = N'(r | ((xe ^ r) >> (tz + 32'd2)));
endmodule

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: streams every N-bit word of a given weight in ascending order; ONES_SELF_CHECK_EN adds a popcount checker driving err
module ones_pattern_gen
  import ones_pkg::*;
#(
  parameter int N  = ONES_N,
  parameter int IW = 7,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] weight,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  pattern,
  output logic [IW-1:0] index,
  output logic          out_last,
  output logic          done,
  output logic          err
);
  localparam logic [KW-1:0] NK = KW'(N);
  state_t state, state_n;
  logic [KW-1:0] k;
  logic [N-1:0] nxt;
  logic fire;
  ones_next_comb #(.N(N)) u_next (.x(pattern), .next(nxt));
  assign busy      = state != IDLE;
  assign out_valid = state == RUN;
  assign done      = state == DONE;
  assign out_last  = out_valid && pattern == N'(last_word(int'(k), N));
  assign fire      = out_valid && out_ready;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next-state: out-of-range weight goes straight to DONE without emitting
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? (weight > NK ? DONE : RUN) : IDLE) :
              state == RUN  ? (fire && out_last ? DONE : RUN) : IDLE;
  end
  // weight latch, word and ordinal registers; all hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      pattern <= '0;
      index   <= '0;
    end else if (state == IDLE && start) begin
      k       <= weight;
      pattern <= N'(first_word(int'(weight)));
      index   <= '0;
    end else if (fire && !out_last) begin
      pattern <= nxt;
      index   <= index + 1'b1;
    end
  end
`ifdef ONES_SELF_CHECK_EN
  logic [KW-1:0] pc;
  // popcount of the word on the stream
  always_comb begin
    pc = '0;
    for (int i = 0; i < N; i++) pc = pc + KW'(pattern[i]);
  end
  // sticky weight mismatch flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (out_valid && pc != k) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen: directed self-checking bench for ones_pattern_gen
module tb_ones_pattern_gen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [3:0] weight = '0;
  logic busy, out_valid, out_last, done, err;
  logic [8:0] pattern;
  logic [6:0] index;
  int tests = 0, fails = 0;
  int words;
  logic [8:0] lastw, exp_w;
  bit seen;

  ones_pattern_gen dut (
    .clk(clk), .rst(rst), .start(start), .weight(weight), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .pattern(pattern), .index(index),
    .out_last(out_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] succ(input logic [8:0] x, input int k);
    logic [8:0] y;
    y = x;
    do y++; while ($countones(y) != k);
    return y;
  endfunction

  task automatic do_start(input logic [3:0] w);
    weight = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_done(input int maxc, output int n, output logic [8:0] lw, output bit s);
    n = 0;
    lw = '0;
    s = 0;
    for (int c = 0; c < maxc && !s; c++) begin
      if (done) s = 1;
      else begin
        if (out_valid && out_ready) begin
          n++;
          lw = pattern;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pattern", pattern, 0);
    chk("rst_index", index, 0);

    // k=2 full run, ready held high
    do_start(2);
    chk("k2_busy", busy, 1);
    exp_w = 9'h003;
    for (int i = 0; i < 36; i++) begin
      chk("k2_valid", out_valid, 1);
      chk("k2_pattern", pattern, exp_w);
      chk("k2_index", index, i);
      chk("k2_last", out_last, i == 35);
      if (i == 3) chk("k2_fourth", pattern, 9'h009);
      if (i == 35) chk("k2_final", pattern, 9'h180);
      exp_w = succ(exp_w, 2);
      @(negedge clk);
    end
    chk("k2_done", done, 1);
    chk("k2_done_valid", out_valid, 0);
    chk("k2_done_busy", busy, 1);
    @(negedge clk);
    chk("k2_idle_busy", busy, 0);
    chk("k2_idle_done", done, 0);

    // k=0 and k=9 single words
    do_start(0);
    chk("k0_pattern", pattern, 9'h000);
    chk("k0_index", index, 0);
    chk("k0_last", out_last, 1);
    chk("k0_valid", out_valid, 1);
    @(negedge clk);
    chk("k0_done", done, 1);
    @(negedge clk);
    do_start(9);
    chk("k9_pattern", pattern, 9'h1FF);
    chk("k9_last", out_last, 1);
    @(negedge clk);
    chk("k9_done", done, 1);
    @(negedge clk);

    // k=1 with backpressure
    out_ready = 1'b0;
    do_start(1);
    for (int i = 0; i < 5; i++) begin
      chk("k1_hold_pattern", pattern, 9'h001);
      chk("k1_hold_index", index, 0);
      chk("k1_hold_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("k1_next_pattern", pattern, 9'h002);
    chk("k1_next_index", index, 1);
    run_to_done(20, words, lastw, seen);
    chk("k1_done_seen", seen, 1);
    chk("k1_words", words, 8);
    chk("k1_lastw", lastw, 9'h100);
    @(negedge clk);

    // k=10 rejected
    do_start(10);
    chk("k10_done", done, 1);
    chk("k10_busy", busy, 1);
    chk("k10_valid", out_valid, 0);
    @(negedge clk);
    chk("k10_idle_busy", busy, 0);
    chk("k10_idle_done", done, 0);
    chk("k10_idle_valid", out_valid, 0);

    // k=4 aborted by reset after 10 handshakes, then k=3
    do_start(4);
    exp_w = 9'h00F;
    for (int i = 0; i < 10; i++) begin
      exp_w = succ(exp_w, 4);
      @(negedge clk);
    end
    chk("k4_index10", index, 10);
    chk("k4_pattern10", pattern, exp_w);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_last", out_last, 0);
    chk("abort_pattern", pattern, 0);
    chk("abort_index", index, 0);
    do_start(3);
    chk("k3_pattern", pattern, 9'h007);
    chk("k3_index", index, 0);
    run_to_done(120, words, lastw, seen);
    chk("k3_done_seen", seen, 1);
    chk("k3_words", words, 84);
    chk("k3_lastw", lastw, 9'h1C0);
    @(negedge clk);

`ifdef ONES_SELF_CHECK_EN
    do_start(4);
    run_to_done(200, words, lastw, seen);
    chk("sc_done_seen", seen, 1);
    chk("sc_words", words, 126);
    chk("sc_err_clean", err, 0);
    @(negedge clk);
    do_start(4);
    force dut.pattern = 9'h10F;
    @(negedge clk);
    release dut.pattern;
    chk("sc_err_set", err, 1);
    repeat (3) @(negedge clk);
    chk("sc_err_sticky", err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("sc_err_cleared", err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
